// File: rtl/issue_instr_queue.sv
// issue_instr_queue: decode-to-issue FIFO with single-outstanding control-flow gating.
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i drops all entries;
//        instr_i/instr_is_ctrl_flow_i/instr_valid_i/instr_ready_o decode-side push handshake;
//        decoded_instr_o/is_ctrl_flow_o/decoded_instr_valid_o/decoded_instr_ack_i issue-side head handshake;
//        resolve_branch_i releases the wait after a control-flow issue; count_o is the occupancy.
package issue_instr_queue_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } scoreboard_entry_t;
endpackage

module issue_instr_queue
    import issue_instr_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  scoreboard_entry_t          instr_i,
    input  logic                       instr_is_ctrl_flow_i,
    input  logic                       instr_valid_i,
    output logic                       instr_ready_o,
    output scoreboard_entry_t          decoded_instr_o,
    output logic                       decoded_instr_valid_o,
    output logic                       is_ctrl_flow_o,
    input  logic                       decoded_instr_ack_i,
    input  logic                       resolve_branch_i,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        scoreboard_entry_t instr;
        logic              ctrl;
    } entry_t;

    typedef enum logic [0:0] {IDLE, WAIT_RESOLVE} state_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    state_t          state, state_n;
    logic            full, empty, push, pop;

    assign full                  = count == CW'(DEPTH);
    assign empty                 = count == '0;
    // Ready depends only on registered occupancy, so a full queue cannot pop and push in one cycle.
    assign instr_ready_o         = !full;
    assign decoded_instr_valid_o = !empty && state == IDLE;
    assign decoded_instr_o       = mem[rd_ptr].instr;
    assign is_ctrl_flow_o        = mem[rd_ptr].ctrl;
    assign count_o               = count;
    assign push                  = instr_valid_i && instr_ready_o;
    assign pop                   = decoded_instr_valid_o && decoded_instr_ack_i;

    // A resolve while IDLE is spurious and ignored, even alongside a control-flow pop.
    always_comb begin
        state_n = state;
        if (flush_i)
            state_n = IDLE;
        else if (state == IDLE && pop && mem[rd_ptr].ctrl)
            state_n = WAIT_RESOLVE;
        else if (state == WAIT_RESOLVE && resolve_branch_i)
            state_n = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_n;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= '{instr: instr_i, ctrl: instr_is_ctrl_flow_i};
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) count <= CW'(DEPTH));
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));
endmodule

// File: tb/tb_issue_instr_queue.sv
// tb_issue_instr_queue: directed and random checks of issue_instr_queue against a queue-based model.
module tb_issue_instr_queue;
    import issue_instr_queue_pkg::*;

    localparam int DEPTH = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              flush_i;
    scoreboard_entry_t instr_i;
    logic              instr_is_ctrl_flow_i;
    logic              instr_valid_i;
    logic              instr_ready_o;
    scoreboard_entry_t decoded_instr_o;
    logic              decoded_instr_valid_o;
    logic              is_ctrl_flow_o;
    logic              decoded_instr_ack_i;
    logic              resolve_branch_i;
    logic [2:0]        count_o;

    issue_instr_queue #(.DEPTH(DEPTH)) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .flush_i               (flush_i),
        .instr_i               (instr_i),
        .instr_is_ctrl_flow_i  (instr_is_ctrl_flow_i),
        .instr_valid_i         (instr_valid_i),
        .instr_ready_o         (instr_ready_o),
        .decoded_instr_o       (decoded_instr_o),
        .decoded_instr_valid_o (decoded_instr_valid_o),
        .is_ctrl_flow_o        (is_ctrl_flow_o),
        .decoded_instr_ack_i   (decoded_instr_ack_i),
        .resolve_branch_i      (resolve_branch_i),
        .count_o               (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        scoreboard_entry_t i;
        bit                c;
    } ment_t;

    ment_t q[$];
    bit    waiting;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("ready", 64'(instr_ready_o), 64'(q.size() < DEPTH));
        chk("valid", 64'(decoded_instr_valid_o), 64'(q.size() != 0 && !waiting));
        chk("count", 64'(count_o), 64'(q.size()));
        chk("head_known", 64'($isunknown({decoded_instr_o, is_ctrl_flow_o})), 64'(0));
        if (q.size() != 0) begin
            chk("head_instr", 64'(decoded_instr_o), 64'(q[0].i));
            chk("head_ctrl", 64'(is_ctrl_flow_o), 64'(q[0].c));
        end
    endtask

    task automatic idle_inputs();
        instr_valid_i        = 1'b0;
        instr_is_ctrl_flow_i = 1'b0;
        instr_i              = '0;
        decoded_instr_ack_i  = 1'b0;
        resolve_branch_i     = 1'b0;
        flush_i              = 1'b0;
    endtask

    // Drives one cycle of inputs, checks the present outputs, advances the model, then waits one clock.
    task automatic step(input bit v, input bit c, input logic [31:0] pc, input bit ack, input bit res, input bit fl);
        scoreboard_entry_t e;
        bit rdy, vld, psh, pp;
        e = '{pc: pc, op: 8'($urandom), rd: 5'($urandom), rs1: 5'($urandom), rs2: 5'($urandom)};
        instr_valid_i        = v;
        instr_is_ctrl_flow_i = c;
        instr_i              = e;
        decoded_instr_ack_i  = ack;
        resolve_branch_i     = res;
        flush_i              = fl;
        check_outputs();
        rdy = q.size() < DEPTH;
        vld = q.size() != 0 && !waiting;
        psh = v && rdy;
        pp  = vld && ack;
        if (fl) begin
            q.delete();
            waiting = 0;
        end else begin
            if (waiting) waiting = !res;
            else if (pp) waiting = q[0].c;
            if (pp) void'(q.pop_front());
            if (psh) q.push_back('{i: e, c: c});
        end
        @(negedge clk_i);
    endtask

    task automatic check_reset_values();
        chk("rst_ready", 64'(instr_ready_o), 64'(1));
        chk("rst_valid", 64'(decoded_instr_valid_o), 64'(0));
        chk("rst_ctrl", 64'(is_ctrl_flow_o), 64'(0));
        chk("rst_count", 64'(count_o), 64'(0));
        chk("rst_instr", 64'(decoded_instr_o), 64'(0));
    endtask

    initial begin
        idle_inputs();
        rst_ni  = 1'b0;
        waiting = 0;
        #1;
        check_reset_values();
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Fill with ack held low, then drain in order.
        for (int k = 0; k < 4; k++) step(1, 0, 32'h8000_0000 + 32'(4 * k), 0, 0, 0);
        chk("fill_ready", 64'(instr_ready_o), 64'(0));
        chk("fill_count", 64'(count_o), 64'(4));
        step(1, 0, 32'hDEAD_0000, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk("drain_pc", 64'(decoded_instr_o.pc), 64'(32'h8000_0000 + 32'(4 * k)));
            step(0, 0, 0, 1, 0, 0);
        end
        chk("drain_count", 64'(count_o), 64'(0));
        chk("drain_valid", 64'(decoded_instr_valid_o), 64'(0));

        // Streaming push/pop through pointer wrap.
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 32'h1000 + 32'(4 * k), 1, 0, 0);
            chk("stream_count", 64'(count_o), 64'(1));
            chk("stream_pc", 64'(decoded_instr_o.pc), 64'(32'h1000 + 32'(4 * k)));
        end
        step(0, 0, 0, 1, 0, 0);

        // Control-flow gating until resolve.
        step(1, 1, 32'h100, 0, 0, 0);
        step(1, 0, 32'h104, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            chk("gate_valid", 64'(decoded_instr_valid_o), 64'(0));
            chk("gate_count", 64'(count_o), 64'(1));
            step(0, 0, 0, 1, 0, 0);
        end
        step(0, 0, 0, 0, 1, 0);
        chk("resolve_valid", 64'(decoded_instr_valid_o), 64'(1));
        chk("resolve_pc", 64'(decoded_instr_o.pc), 64'(32'h104));
        step(0, 0, 0, 1, 0, 0);

        // Resolve coinciding with a control-flow pop is spurious.
        step(1, 1, 32'h200, 0, 0, 0);
        step(1, 0, 32'h204, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        chk("same_cyc_valid", 64'(decoded_instr_valid_o), 64'(0));
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        chk("late_resolve_pc", 64'(decoded_instr_o.pc), 64'(32'h204));
        step(0, 0, 0, 1, 0, 0);

        // Flush with a simultaneous push while three entries are queued.
        for (int k = 0; k < 3; k++) step(1, 0, 32'h300 + 32'(4 * k), 0, 0, 0);
        step(1, 0, 32'h30C, 1, 0, 1);
        chk("flush_count", 64'(count_o), 64'(0));
        chk("flush_valid", 64'(decoded_instr_valid_o), 64'(0));
        chk("flush_ready", 64'(instr_ready_o), 64'(1));
        step(0, 0, 0, 1, 0, 0);

        // Asynchronous reset while waiting for a resolve with two entries left.
        step(1, 1, 32'h400, 0, 0, 0);
        step(1, 0, 32'h404, 0, 0, 0);
        step(1, 0, 32'h408, 1, 0, 0);
        chk("pre_rst_count", 64'(count_o), 64'(2));
        chk("pre_rst_valid", 64'(decoded_instr_valid_o), 64'(0));
        idle_inputs();
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_values();
        q.delete();
        waiting = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(1, 0, 32'h500, 0, 0, 0);
        chk("post_rst_valid", 64'(decoded_instr_valid_o), 64'(1));
        chk("post_rst_pc", 64'(decoded_instr_o.pc), 64'(32'h500));
        step(0, 0, 0, 1, 0, 0);

        // Random traffic.
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 32'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0);
        idle_inputs();
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
